cpu_stack_writeback: RTL and testbench
======================================

# cpu_stack_writeback

Final (5a) pipeline stage of the stack CPU. It consumes the memory stage's push/pop/branch results, maintains the architectural operand stack, and presents the top two entries to decode. The top two entries live in a two-register cache. Deeper entries spill to a single-port synchronous RAM. Deep pops stall the pipeline while the cache refills. Taken branches (`kill_4a`) are turned into a one-cycle fetch redirect.

## Interface
Parameters:
- `DEPTH_LOG2`, default 10: total stack capacity is `CAP = 2**DEPTH_LOG2` entries.
- `WIDTH`, default 35: entry width, `{type[2:0], data[31:0]}`.

Ports:
- `clk` in, 1: clock.
- `rst_b` in, 1: reset, asynchronous, active-low.
- `valid_4a` in, 1: stage-4 outputs are meaningful this cycle.
- `c__to_push_4a` in, 3: push selector; a push occurs iff the value is not `UC_PUSHNONE`.
- `st__to_push_4a` in, 35: entry to push.
- `st__to_pop_4a` in, 11: number of entries to pop (0..CAP).
- `kill_4a` in, 1: branch taken.
- `branch_target_4a` in, 32: redirect target.
- `tos0_5a` out, 35: top of stack (entry sp-1); 0 when sp<1.
- `tos1_5a` out, 35: second entry (entry sp-2); 0 when sp<2.
- `sp_5a` out, 11: current depth.
- `stall_5a` out, 1: upstream must hold its stage-4 outputs; `valid_4a` is ignored while high.
- `redirect_5a` out, 1: one-cycle fetch redirect.
- `redirect_pc_5a` out, 32: target for the redirect.
- `err_underflow` out, 1: sticky flag.
- `err_overflow` out, 1: sticky flag.

## Operation
- An operation is accepted when `valid_4a && !stall_5a`. Pop is applied before push: `n = sp - p + u`, where u is 1 when a push occurs.
- Entry i (0 = bottom) for i ≤ sp-3 lives at RAM address i.
- **p=0, u=1:** if sp≥2, write `tos1` to RAM[sp-2]. Then `tos1 <= tos0` and `tos0 <= push`.
- **p=0, u=0:** no change.
- **p≥1, u=1:** `tos0 <= push`. If p=1, `tos1` is unchanged. If p≥2, `tos1` is refilled from RAM[n-2] when n≥2, and cleared otherwise.
- **p=1, u=0:** `tos0 <= tos1`. `tos1` is refilled from RAM[n-2] when n≥2, else cleared.
- **p≥2, u=0:** `tos1` is refilled from RAM[n-2] when n≥2. `tos0` is refilled from RAM[n-1] when n≥1. Either slot is cleared when its entry does not exist.
- At most one RAM access occurs per cycle; writes and refills never coincide.
- **FSM states:**
  - RUN: idle.
  - FILL1: waiting on the `tos1` read.
  - FILL0: waiting on the `tos0` read.
- **FSM transitions:**
  - From RUN on an accepted op: to FILL1 if `tos1` needs a refill, else to FILL0 if only `tos0` does, else stay in RUN.
  - FILL1 captures its data. It then goes to FILL0 if `tos0` is also pending (issuing RAM[n-1] that cycle), else to RUN.
  - FILL0 captures its data and goes to RUN.
- **Redirect:** an accepted op with `kill_4a` gives `redirect_5a = 1` and `redirect_pc_5a = branch_target_4a` on the next cycle. The redirect is independent of stack activity.
- **Reset:** all outputs 0, FSM in RUN, sp = 0. Reset asserted mid-refill aborts the refill.

## Timing
- Stack outputs, `sp_5a`, and the redirect update one cycle after acceptance.
- `stall_5a` is registered. It is high for exactly k cycles after the op cycle, where k is the number of refills (0, 1 or 2).
- `tos` outputs are final when `stall_5a` deasserts.
- Back-to-back pushes sustain one push per cycle.

## Configuration
`CPU_STACK_CHECK_EN`:
- **Defined, underflow** (p > sp): sp saturates to 0 and both `tos` outputs are cleared. The push is still applied when u=1, giving sp = 1 with `tos0` = pushed entry. `err_underflow` is set.
- **Defined, overflow** (n > CAP): the push is dropped, the pop still applies, and `err_overflow` is set.
- Both flags clear only on reset.
- **Undefined:** no checks are made, both flags are tied 0, and underflow/overflow behaviour is undefined.

## Structure
- `opcode.vh` owns the `UC_PUSH*` encodings, including `UC_PUSHNONE`, and `TYPE_*`.
- The FSM state encodings are local parameters.
- One sub-module, `stack_ram`: single-port synchronous RAM, `CAP-2` × `WIDTH`, one-cycle read latency.

## Test plan
- Push 1,2,3 on consecutive cycles from reset → `sp_5a` = 3, `tos0` = 3, `tos1` = 2, RAM[0] = 1, `stall_5a` never high.
- From stack [1,2,3,4], p=2, u=0 → 2 stall cycles, then sp = 2, `tos0` = 2, `tos1` = 1.
- From [1,2,3], p=1, u=1 push 9 → no stall, sp = 3, `tos0` = 9, `tos1` = 2.
- With `kill_4a` = 1 and `branch_target_4a` = 0x100 → `redirect_5a` high one cycle with `redirect_pc_5a` = 0x100.
- From sp = 1, p=3 with check on → `err_underflow` = 1, sp = 0, `tos0` = 0. At sp = CAP, push → `err_overflow` = 1, sp stays CAP.
- Assert `rst_b` low during FILL1 → all outputs 0 and `stall_5a` = 0 immediately.

Source files
------------

// File: rtl/cpu_stack_writeback_pkg.sv
// Shared stack-CPU encodings (push selectors, entry type tags) used by the writeback stage.
package cpu_stack_writeback_pkg;

    localparam logic [2:0] UC_PUSHNONE = 3'd0;
    localparam logic [2:0] UC_PUSHIMM  = 3'd1;
    localparam logic [2:0] UC_PUSHALU  = 3'd2;
    localparam logic [2:0] UC_PUSHMEM  = 3'd3;
    localparam logic [2:0] UC_PUSHPC   = 3'd4;

    localparam logic [2:0] TYPE_INT    = 3'd0;
    localparam logic [2:0] TYPE_PTR    = 3'd1;
    localparam logic [2:0] TYPE_RET    = 3'd2;
    localparam logic [2:0] TYPE_BOOL   = 3'd3;

    function automatic logic is_push(input logic [2:0] c);
        return c != UC_PUSHNONE;
    endfunction

endpackage

// File: rtl/cpu_stack_writeback_stack_ram.sv
// Single-port synchronous spill RAM for stack entries below the two-entry cache; 1-cycle read.
module stack_ram #(
    parameter int AW    = 10,
    parameter int WIDTH = 35,
    parameter int DEPTH = 1022
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i)
            mem_q[addr_i] <= wdata_i;
        else if (re_i)
            rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_stack_writeback.sv
// Stack CPU writeback: two-entry TOS cache over a spill RAM, refill FSM, branch redirect.
// Define CPU_STACK_CHECK_EN to enable underflow/overflow handling and sticky error flags.
module cpu_stack_writeback
    import cpu_stack_writeback_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int WIDTH      = 35
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  valid_4a,
    input  logic [2:0]            c__to_push_4a,
    input  logic [WIDTH-1:0]      st__to_push_4a,
    input  logic [DEPTH_LOG2:0]   st__to_pop_4a,
    input  logic                  kill_4a,
    input  logic [31:0]           branch_target_4a,
    output logic [WIDTH-1:0]      tos0_5a,
    output logic [WIDTH-1:0]      tos1_5a,
    output logic [DEPTH_LOG2:0]   sp_5a,
    output logic                  stall_5a,
    output logic                  redirect_5a,
    output logic [31:0]           redirect_pc_5a,
    output logic                  err_underflow,
    output logic                  err_overflow
);

    localparam int SPW       = DEPTH_LOG2 + 1;
    localparam int AW        = DEPTH_LOG2;
    localparam int RAM_DEPTH = (1 << DEPTH_LOG2) - 2;
    localparam logic [SPW-1:0] CAP = {1'b1, {AW{1'b0}}};
    localparam logic [SPW-1:0] SP1 = SPW'(1);
    localparam logic [SPW-1:0] SP2 = SPW'(2);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_FILL1 = 2'd1;
    localparam logic [1:0] S_FILL0 = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             stall_q, stall_d;
    logic [SPW-1:0]   sp_q, sp_d, n;
    logic [WIDTH-1:0] tos0_q, tos0_d, tos1_q, tos1_d;
    logic             fill0_q, fill0_d;
    logic             redir_q;
    logic [31:0]      redir_pc_q;
    logic             accept, push_req, push, uf, ovf, need1, need0;
    logic             ram_we, ram_re;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_rdata;

    assign accept   = valid_4a && !stall_q;
    assign push_req = accept && is_push(c__to_push_4a);

`ifdef CPU_STACK_CHECK_EN
    assign uf  = accept && (st__to_pop_4a > sp_q);
    assign ovf = push_req && !uf && ((sp_q - st__to_pop_4a + SP1) > CAP);
`else
    assign uf  = 1'b0;
    assign ovf = 1'b0;
`endif

    assign push = push_req && !ovf;
    assign n    = uf ? SPW'(push) : sp_q - st__to_pop_4a + SPW'(push);

    // Cache update; slots awaiting a refill read as 0 until the RAM data lands.
    always_comb begin
        sp_d    = sp_q;
        tos0_d  = tos0_q;
        tos1_d  = tos1_q;
        fill0_d = fill0_q;
        need1   = 1'b0;
        need0   = 1'b0;
        if (accept) begin
            sp_d = n;
            if (uf) begin
                tos0_d = push ? st__to_push_4a : '0;
                tos1_d = '0;
            end else if (st__to_pop_4a == '0) begin
                if (push) begin
                    tos1_d = tos0_q;
                    tos0_d = st__to_push_4a;
                end
            end else if (st__to_pop_4a == SP1) begin
                if (push) begin
                    tos0_d = st__to_push_4a;
                end else begin
                    tos0_d = tos1_q;
                    tos1_d = '0;
                    need1  = n >= SP2;
                end
            end else begin
                tos1_d = '0;
                need1  = n >= SP2;
                if (push) begin
                    tos0_d = st__to_push_4a;
                end else begin
                    tos0_d = '0;
                    need0  = n >= SP1;
                end
            end
            fill0_d = need1 && need0;
        end else if (state_q == S_FILL1) begin
            tos1_d = ram_rdata;
        end else if (state_q == S_FILL0) begin
            tos0_d = ram_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_RUN;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (accept && need1)
                    state_d = S_FILL1;
                else if (accept && need0)
                    state_d = S_FILL0;
            end
            S_FILL1: state_d = fill0_q ? S_FILL0 : S_RUN;
            S_FILL0: state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    // One RAM access per cycle: spill on a plain push, else the first pending refill read.
    always_comb begin
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = '0;
        stall_d  = state_d != S_RUN;
        case (state_q)
            S_RUN: begin
                if (accept && !uf && st__to_pop_4a == '0 && push && sp_q >= SP2) begin
                    ram_we   = 1'b1;
                    ram_addr = AW'(sp_q - SP2);
                end else if (accept && need1) begin
                    ram_re   = 1'b1;
                    ram_addr = AW'(n - SP2);
                end else if (accept && need0) begin
                    ram_re   = 1'b1;
                    ram_addr = AW'(n - SP1);
                end
            end
            S_FILL1: begin
                if (fill0_q) begin
                    ram_re   = 1'b1;
                    ram_addr = AW'(sp_q - SP1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sp_q       <= '0;
            tos0_q     <= '0;
            tos1_q     <= '0;
            fill0_q    <= 1'b0;
            redir_q    <= 1'b0;
            redir_pc_q <= '0;
        end else begin
            sp_q    <= sp_d;
            tos0_q  <= tos0_d;
            tos1_q  <= tos1_d;
            fill0_q <= fill0_d;
            redir_q <= accept && kill_4a;
            if (accept && kill_4a)
                redir_pc_q <= branch_target_4a;
        end
    end

`ifdef CPU_STACK_CHECK_EN
    logic uf_q, ovf_q;
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            uf_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            uf_q  <= uf_q | uf;
            ovf_q <= ovf_q | ovf;
        end
    end
    assign err_underflow = uf_q;
    assign err_overflow  = ovf_q;
`else
    assign err_underflow = 1'b0;
    assign err_overflow  = 1'b0;
`endif

    stack_ram #(
        .AW    (AW),
        .WIDTH (WIDTH),
        .DEPTH (RAM_DEPTH)
    ) u_stack_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (tos1_q),
        .rdata_o (ram_rdata)
    );

    assign tos0_5a        = tos0_q;
    assign tos1_5a        = tos1_q;
    assign sp_5a          = sp_q;
    assign stall_5a       = stall_q;
    assign redirect_5a    = redir_q;
    assign redirect_pc_5a = redir_pc_q;

endmodule

// File: tb/tb_cpu_stack_writeback.sv
// Randomized bench for cpu_stack_writeback against a queue-based stack model.
module tb_cpu_stack_writeback;
    import cpu_stack_writeback_pkg::*;

    localparam int CAP = 1024;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        valid_4a = 1'b0;
    logic [2:0]  c__to_push_4a = UC_PUSHNONE;
    logic [34:0] st__to_push_4a = '0;
    logic [10:0] st__to_pop_4a = '0;
    logic        kill_4a = 1'b0;
    logic [31:0] branch_target_4a = '0;
    logic [34:0] tos0_5a, tos1_5a;
    logic [10:0] sp_5a;
    logic        stall_5a, redirect_5a, err_underflow, err_overflow;
    logic [31:0] redirect_pc_5a;

    int n_checks = 0;
    int n_fail   = 0;
    logic [34:0] stk[$];
    bit m_uf = 0, m_ovf = 0;

    always #5 clk = ~clk;

    cpu_stack_writeback dut (
        .clk(clk), .rst_b(rst_b), .valid_4a(valid_4a), .c__to_push_4a(c__to_push_4a),
        .st__to_push_4a(st__to_push_4a), .st__to_pop_4a(st__to_pop_4a), .kill_4a(kill_4a),
        .branch_target_4a(branch_target_4a), .tos0_5a(tos0_5a), .tos1_5a(tos1_5a),
        .sp_5a(sp_5a), .stall_5a(stall_5a), .redirect_5a(redirect_5a),
        .redirect_pc_5a(redirect_pc_5a), .err_underflow(err_underflow), .err_overflow(err_overflow)
    );

    function automatic logic [34:0] etos(input int i);
        return (stk.size() > i) ? stk[stk.size()-1-i] : 35'd0;
    endfunction

    function automatic logic [34:0] rnd_entry();
        return {3'($urandom_range(0, 4)), 32'($urandom())};
    endfunction

    task automatic do_reset();
        rst_b = 1'b0;
        valid_4a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        stk.delete();
        m_uf = 0;
        m_ovf = 0;
    endtask

    // One accepted op, then wait out the refill and compare everything with the model.
    task automatic op(input int p, input bit u_in, input logic [34:0] d,
                      input bit kill, input logic [31:0] tgt, input string nm);
        int n, k, exp_k;
        bit u;
        u = u_in;
        exp_k = 0;
        if (p > stk.size()) begin
            stk.delete();
            if (u) stk.push_back(d);
`ifdef CPU_STACK_CHECK_EN
            m_uf = 1;
`endif
        end else begin
            n = stk.size() - p + int'(u);
            if (n > CAP) begin
                u = 0;
                n = n - 1;
`ifdef CPU_STACK_CHECK_EN
                m_ovf = 1;
`endif
            end
            repeat (p) void'(stk.pop_back());
            if (u) stk.push_back(d);
            exp_k = int'((p >= 2 || (p == 1 && !u)) && n >= 2) + int'(p >= 2 && !u && n >= 1);
        end
        @(negedge clk);
        valid_4a = 1'b1;
        c__to_push_4a = u_in ? 3'($urandom_range(1, 4)) : UC_PUSHNONE;
        st__to_push_4a = d;
        st__to_pop_4a = 11'(p);
        kill_4a = kill;
        branch_target_4a = tgt;
        @(posedge clk);
        #1;
        valid_4a = 1'b0;
        c__to_push_4a = UC_PUSHNONE;
        st__to_pop_4a = '0;
        kill_4a = 1'b0;
        n_checks++;
        if (redirect_5a !== kill) begin
            n_fail++;
            $display("FAIL %s redirect: got %b expected %b", nm, redirect_5a, kill);
        end
        if (kill) begin
            n_checks++;
            if (redirect_pc_5a !== tgt) begin
                n_fail++;
                $display("FAIL %s redirect_pc: got %h expected %h", nm, redirect_pc_5a, tgt);
            end
        end
        k = 0;
        while (stall_5a === 1'b1 && k < 8) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_checks += 6;
        if (k != exp_k) begin
            n_fail++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", nm, k, exp_k);
        end
        if (sp_5a !== 11'(stk.size())) begin
            n_fail++;
            $display("FAIL %s sp: got %0d expected %0d", nm, sp_5a, stk.size());
        end
        if (tos0_5a !== etos(0)) begin
            n_fail++;
            $display("FAIL %s tos0: got %h expected %h", nm, tos0_5a, etos(0));
        end
        if (tos1_5a !== etos(1)) begin
            n_fail++;
            $display("FAIL %s tos1: got %h expected %h", nm, tos1_5a, etos(1));
        end
        if (err_underflow !== m_uf) begin
            n_fail++;
            $display("FAIL %s err_underflow: got %b expected %b", nm, err_underflow, m_uf);
        end
        if (err_overflow !== m_ovf) begin
            n_fail++;
            $display("FAIL %s err_overflow: got %b expected %b", nm, err_overflow, m_ovf);
        end
    endtask

    // Consecutive-cycle pushes; stall must stay low throughout.
    task automatic push_burst(input int cnt, input bit seq, input string nm);
        int stalls;
        logic [34:0] d;
        stalls = 0;
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk);
            if (stall_5a !== 1'b0) stalls++;
            d = seq ? 35'(i + 1) : rnd_entry();
            valid_4a = 1'b1;
            c__to_push_4a = UC_PUSHALU;
            st__to_push_4a = d;
            st__to_pop_4a = '0;
            stk.push_back(d);
        end
        @(negedge clk);
        valid_4a = 1'b0;
        c__to_push_4a = UC_PUSHNONE;
        n_checks += 4;
        if (stalls != 0 || stall_5a !== 1'b0) begin
            n_fail++;
            $display("FAIL %s stall: got %0d stalled cycles expected 0", nm, stalls);
        end
        if (sp_5a !== 11'(stk.size())) begin
            n_fail++;
            $display("FAIL %s sp: got %0d expected %0d", nm, sp_5a, stk.size());
        end
        if (tos0_5a !== etos(0)) begin
            n_fail++;
            $display("FAIL %s tos0: got %h expected %h", nm, tos0_5a, etos(0));
        end
        if (tos1_5a !== etos(1)) begin
            n_fail++;
            $display("FAIL %s tos1: got %h expected %h", nm, tos1_5a, etos(1));
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        n_checks += 3;
        if ({tos0_5a, tos1_5a, sp_5a} !== '0) begin
            n_fail++;
            $display("FAIL reset stack: got sp=%0d tos0=%h tos1=%h expected 0", sp_5a, tos0_5a, tos1_5a);
        end
        if ({stall_5a, redirect_5a, redirect_pc_5a} !== '0) begin
            n_fail++;
            $display("FAIL reset ctl: got stall=%b redir=%b pc=%h expected 0", stall_5a, redirect_5a, redirect_pc_5a);
        end
        if ({err_underflow, err_overflow} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset flags: got %b%b expected 00", err_underflow, err_overflow);
        end
        do_reset();
    endtask

    task automatic test_push3();
        do_reset();
        push_burst(3, 1'b1, "push3");
        op(2, 1'b0, '0, 1'b0, '0, "push3_pop2_ram0");
    endtask

    task automatic test_pop2();
        do_reset();
        push_burst(4, 1'b1, "pop2_fill");
        op(2, 1'b0, '0, 1'b0, '0, "pop2");
    endtask

    task automatic test_pop_push();
        do_reset();
        push_burst(3, 1'b1, "poppush_fill");
        op(1, 1'b1, 35'd9, 1'b0, '0, "pop1_push9");
        op(1, 1'b0, '0, 1'b0, '0, "pop1_refill");
    endtask

    task automatic test_redirect();
        op(0, 1'b0, '0, 1'b1, 32'h100, "redirect");
        @(posedge clk);
        #1;
        n_checks++;
        if (redirect_5a !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_one_cycle: got %b expected 0", redirect_5a);
        end
        op(2, 1'b1, rnd_entry(), 1'b1, 32'hdead_beef, "redirect_with_pop");
    endtask

    task automatic test_random();
        int p, mx;
        bit u;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            mx = stk.size() < 3 ? stk.size() : 3;
            p = ($urandom_range(0, 9) < 8) ? $urandom_range(0, mx) : $urandom_range(0, stk.size());
            u = $urandom_range(0, 99) < 65;
            op(p, u, rnd_entry(), $urandom_range(0, 7) == 0, $urandom(), "random");
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push_burst(CAP, 1'b0, "fill_to_cap");
`ifdef CPU_STACK_CHECK_EN
        op(0, 1'b1, rnd_entry(), 1'b0, '0, "overflow");
`endif
        op(2, 1'b0, '0, 1'b0, '0, "pop2_at_cap");
        op(stk.size() - 1, 1'b0, '0, 1'b0, '0, "pop_to_one");
        op(1, 1'b0, '0, 1'b0, '0, "pop_to_empty");
    endtask

    task automatic test_underflow();
        do_reset();
        op(0, 1'b1, 35'd7, 1'b0, '0, "uf_setup");
`ifdef CPU_STACK_CHECK_EN
        op(3, 1'b0, '0, 1'b0, '0, "underflow");
        op(0, 1'b1, 35'd5, 1'b0, '0, "uf_setup2");
        op(4, 1'b1, 35'h4_1234_5678, 1'b0, '0, "underflow_push");
`else
        op(1, 1'b0, '0, 1'b0, '0, "pop_last");
`endif
    endtask

    task automatic test_reset_mid_fill();
        do_reset();
        push_burst(4, 1'b1, "midfill_fill");
        @(negedge clk);
        valid_4a = 1'b1;
        st__to_pop_4a = 11'd2;
        @(posedge clk);
        #1;
        valid_4a = 1'b0;
        st__to_pop_4a = '0;
        n_checks++;
        if (stall_5a !== 1'b1) begin
            n_fail++;
            $display("FAIL midfill_stall: got %b expected 1", stall_5a);
        end
        rst_b = 1'b0;
        #1;
        n_checks += 2;
        if ({tos0_5a, tos1_5a, sp_5a, redirect_5a, redirect_pc_5a} !== '0) begin
            n_fail++;
            $display("FAIL midfill_reset_outputs: got sp=%0d tos0=%h tos1=%h expected 0", sp_5a, tos0_5a, tos1_5a);
        end
        if (stall_5a !== 1'b0) begin
            n_fail++;
            $display("FAIL midfill_reset_stall: got %b expected 0", stall_5a);
        end
        @(negedge clk);
        rst_b = 1'b1;
        stk.delete();
        m_uf = 0;
        m_ovf = 0;
        op(0, 1'b1, 35'h3, 1'b0, '0, "after_midfill_reset");
    endtask

    initial begin
        test_reset();
        test_push3();
        test_pop2();
        test_pop_push();
        test_redirect();
        test_underflow();
        test_reset_mid_fill();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running after 90000 cycles, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
